// File: rtl/wb_stage_regfile.sv
// Writeback stage and integer register file: selects ALU or load write data, waits on
// load responses with a bounded timeout, exposes two bypassed read ports and a retire count.
module wb_stage_regfile #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WB_VALID,
  input  logic [4:0]      WB_RD,
  input  logic            WB_RegWrite,
  input  logic            WB_MemRead,
  input  logic            WB_MemToReg,
  input  logic [XLEN-1:0] WB_EXE_RESULT,
  input  logic [31:0]     WB_PC,
  input  logic [XLEN-1:0] DMEM_RDATA,
  input  logic            DMEM_RVALID,
  input  logic [4:0]      RS1_ADDR,
  input  logic [4:0]      RS2_ADDR,
  output logic [XLEN-1:0] RS1_DATA,
  output logic [XLEN-1:0] RS2_DATA,
  output logic            STALL,
  output logic [31:0]     RETIRE_COUNT,
  output logic            LOAD_ERR
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      timer_q, timer_d;
  logic [31:0]     retire_cnt_q, retire_cnt_d;
  logic            load_err_q, load_err_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic            needs_load, retire_now, abort, stall;
  logic            rd_ok, we;
  logic [XLEN-1:0] wdata;

  // PC is carried for trace purposes only; nothing in this stage consumes it.
  logic unused_pc;
  assign unused_pc = ^WB_PC;

  assign needs_load = WB_VALID & WB_MemRead & WB_MemToReg;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retire_now = 1'b0;
    abort      = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (needs_load) begin
          if (DMEM_RVALID) begin
            retire_now = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = LOAD_WAIT;
            timer_d = 8'd0;
          end
        end else if (WB_VALID) begin
          retire_now = 1'b1;
        end
      end
      LOAD_WAIT: begin
        if (DMEM_RVALID) begin
          retire_now = 1'b1;
          state_d    = IDLE;
        end else if (timer_q == 8'(LOAD_TIMEOUT - 1)) begin
          // Give up on the load: the entry retires without writing.
          retire_now = 1'b1;
          abort      = 1'b1;
          state_d    = IDLE;
        end else begin
          stall   = 1'b1;
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_ok = (WB_RD != 5'd0) && (32'(WB_RD) < NREG);
  assign we    = retire_now & WB_RegWrite & rd_ok & ~abort;
  assign wdata = WB_MemToReg ? DMEM_RDATA : WB_EXE_RESULT;

  always_comb begin
    regs_d       = regs_q;
    retire_cnt_d = retire_cnt_q;
    load_err_d   = load_err_q;
    if (we) regs_d[WB_RD[AW-1:0]] = wdata;
    if (retire_now) retire_cnt_d = retire_cnt_q + 32'd1;
    if (abort) load_err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      timer_q      <= 8'd0;
      retire_cnt_q <= 32'd0;
      load_err_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retire_cnt_q <= retire_cnt_d;
      load_err_q   <= load_err_d;
      regs_q       <= regs_d;
    end
  end

  // x0 and out-of-range addresses read zero; a same-cycle write is forwarded.
  always_comb begin
    RS1_DATA = '0;
    RS2_DATA = '0;
    if (RS1_ADDR != 5'd0 && 32'(RS1_ADDR) < NREG)
      RS1_DATA = (we && WB_RD == RS1_ADDR) ? wdata : regs_q[RS1_ADDR[AW-1:0]];
    if (RS2_ADDR != 5'd0 && 32'(RS2_ADDR) < NREG)
      RS2_DATA = (we && WB_RD == RS2_ADDR) ? wdata : regs_q[RS2_ADDR[AW-1:0]];
  end

  assign STALL        = stall;
  assign RETIRE_COUNT = retire_cnt_q;
  assign LOAD_ERR     = load_err_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Scoreboarded bench for wb_stage_regfile: the driver predicts each retire, a monitor checks it.
module tb_wb_stage_regfile;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int LT   = 15;

  logic            CLK = 1'b0;
  logic            RST;
  logic            WB_VALID, WB_RegWrite, WB_MemRead, WB_MemToReg, DMEM_RVALID;
  logic [4:0]      WB_RD, RS1_ADDR, RS2_ADDR;
  logic [XLEN-1:0] WB_EXE_RESULT, DMEM_RDATA, RS1_DATA, RS2_DATA;
  logic [31:0]     WB_PC, RETIRE_COUNT;
  logic            STALL, LOAD_ERR;

  wb_stage_regfile #(.XLEN(XLEN), .NREG(NREG), .LOAD_TIMEOUT(LT)) dut (
    .CLK(CLK), .RST(RST), .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_RegWrite(WB_RegWrite),
    .WB_MemRead(WB_MemRead), .WB_MemToReg(WB_MemToReg), .WB_EXE_RESULT(WB_EXE_RESULT),
    .WB_PC(WB_PC), .DMEM_RDATA(DMEM_RDATA), .DMEM_RVALID(DMEM_RVALID),
    .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .STALL(STALL), .RETIRE_COUNT(RETIRE_COUNT), .LOAD_ERR(LOAD_ERR));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rs1, rs2, cnt;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_regs [NREG];
  logic [31:0] model_cnt;
  logic        model_err;
  int          checks = 0, failures = 0;
  int          stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    model_cnt = '0;
    model_err = 1'b0;
  endtask

  // A retire is visible as a valid entry that is not being held.
  always @(negedge CLK) begin
    if (RST) stall_cnt = 0;
    else if (STALL) begin
      stall_cnt++;
      if (stall_cnt > LT + 1) begin
        chk("stall_bound", 32'(stall_cnt), 32'(LT));
        stall_cnt = 0;
      end
    end else if (WB_VALID) begin
      if (sb.size() == 0) chk("unexpected_retire", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rs1_bypass", RS1_DATA, e.rs1);
        chk("rs2_read", RS2_DATA, e.rs2);
        chk("retire_count", RETIRE_COUNT, e.cnt);
        chk("load_err", 32'(LOAD_ERR), 32'(e.err));
        chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
      end
      stall_cnt = 0;
    end
  end

  // lat: cycles after issue at which the load response arrives; lat > LT means never.
  task automatic do_txn(input bit ld, input int lat, input logic [4:0] rd, input bit rw,
                        input logic [31:0] exe, input logic [31:0] ldata, input logic [4:0] rs2);
    exp_t        e;
    bit          abort, we;
    logic [31:0] wdata;
    int          n;
    abort = ld && (lat > LT);
    wdata = ld ? ldata : exe;
    we    = rw && (rd != 0) && !abort;
    e.rs1    = (rd == 0) ? 32'd0 : (we ? wdata : model_regs[rd]);
    e.rs2    = (rs2 == 0) ? 32'd0 : ((we && rs2 == rd) ? wdata : model_regs[rs2]);
    e.cnt    = model_cnt;
    e.err    = model_err;
    e.stalls = ld ? (abort ? LT : lat) : 0;
    sb.push_back(e);
    if (we) model_regs[rd] = wdata;
    model_cnt = model_cnt + 32'd1;
    if (abort) model_err = 1'b1;

    @(posedge CLK); #1;
    WB_VALID = 1'b1; WB_RD = rd; WB_RegWrite = rw;
    WB_MemRead = ld ? 1'b1 : 1'($urandom_range(0, 1));
    WB_MemToReg = ld; WB_EXE_RESULT = exe; WB_PC = $urandom;
    DMEM_RDATA = ldata; RS1_ADDR = rd; RS2_ADDR = rs2;
    DMEM_RVALID = ld ? (lat == 0) : 1'($urandom_range(0, 1));
    n = ld ? (abort ? LT : lat) : 0;
    for (int c = 1; c <= n; c++) begin
      @(posedge CLK); #1;
      DMEM_RVALID = !abort && (c == lat);
    end
  endtask

  task automatic go_idle();
    @(posedge CLK); #1;
    WB_VALID = 1'b0; DMEM_RVALID = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [4:0] b);
    go_idle();
    RS1_ADDR = a; RS2_ADDR = b;
    @(negedge CLK);
    chk("rd_port1", RS1_DATA, model_regs[a]);
    chk("rd_port2", RS2_DATA, model_regs[b]);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1; WB_VALID = 1'b0; DMEM_RVALID = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    sb.delete();
  endtask

  initial begin
    RST = 1'b1; WB_VALID = 0; WB_RD = 0; WB_RegWrite = 0; WB_MemRead = 0; WB_MemToReg = 0;
    WB_EXE_RESULT = 0; WB_PC = 0; DMEM_RDATA = 0; DMEM_RVALID = 0; RS1_ADDR = 0; RS2_ADDR = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_stall", 32'(STALL), 32'd0);
    chk("reset_count", RETIRE_COUNT, 32'd0);
    chk("reset_err", 32'(LOAD_ERR), 32'd0);
    rd_chk(5'd5, 5'd31);

    // ALU write with bypass, then storage read; x0 write; late load; timed-out load
    do_txn(0, 0, 5'd5, 1, 32'h1234, 32'h0, 5'd5);
    rd_chk(5'd5, 5'd0);
    chk("t1_count", RETIRE_COUNT, 32'd1);
    do_txn(0, 0, 5'd0, 1, 32'hFFFF, 32'h0, 5'd5);
    rd_chk(5'd0, 5'd5);
    do_txn(1, 3, 5'd7, 1, 32'h100, 32'hCAFEF00D, 5'd5);
    rd_chk(5'd7, 5'd5);
    do_txn(1, 99, 5'd7, 1, 32'h104, 32'hDEADBEEF, 5'd7);
    rd_chk(5'd7, 5'd5);
    chk("t4_err", 32'(LOAD_ERR), 32'd1);

    // Reset while the load is outstanding, two cycles into the wait
    @(posedge CLK); #1;
    WB_VALID = 1; WB_RD = 5'd9; WB_RegWrite = 1; WB_MemRead = 1; WB_MemToReg = 1;
    DMEM_RVALID = 0; DMEM_RDATA = 32'h5555AAAA;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; WB_VALID = 0;
    model_reset();
    @(negedge CLK);
    chk("t5_stall", 32'(STALL), 32'd0);
    chk("t5_count", RETIRE_COUNT, 32'd0);
    chk("t5_err", 32'(LOAD_ERR), 32'd0);
    for (int i = 0; i < NREG; i += 2) rd_chk(5'(i), 5'(i + 1));

    // Counter wrap from all-ones
    @(posedge CLK); #1;
    force dut.retire_cnt_q = 32'hFFFFFFFF;
    #1 release dut.retire_cnt_q;
    model_cnt = 32'hFFFFFFFF;
    do_txn(0, 0, 5'd3, 1, 32'hA5A5A5A5, 32'h0, 5'd3);
    go_idle();
    @(negedge CLK);
    chk("t6_wrap", RETIRE_COUNT, 32'd0);

    do_reset();
    for (int k = 0; k < 400; k++) begin
      bit ld;
      int lat;
      ld  = ($urandom_range(0, 2) == 0);
      lat = ($urandom_range(0, 9) == 0) ? LT + 1 + $urandom_range(0, 5) : $urandom_range(0, LT);
      do_txn(ld, lat, 5'($urandom), 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
             5'($urandom));
      if ($urandom_range(0, 7) == 0) go_idle();
    end
    go_idle();
    for (int i = 0; i < NREG; i += 2) rd_chk(5'(i), 5'(i + 1));
    @(negedge CLK);
    chk("final_count", RETIRE_COUNT, model_cnt);
    chk("final_err", 32'(LOAD_ERR), 32'(model_err));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, failures=%0d", failures);
    $fatal(1);
  end
endmodule
